op_dispatcher: RTL and testbench
================================

Name: op_dispatcher

Overview:
- Sequences the per-opcode processing units of the plotter command path.
- Accepts one decoded opcode at a time from the OP field decoder. Applies the pen-servo state the opcode requires and waits for the servo to settle. Then triggers either the linear or the circular processing unit and waits for its done before accepting the next opcode.
- Owns the pen state and the arc direction. Flags illegal opcodes and hung units.

Parameters:
- PEN_SETTLE_CYCLES, 4, number of clk_en-qualified cycles to wait after a pen change; 0 means no wait.
- TIMEOUT_CYCLES, 1000000, number of clk_en-qualified cycles allowed in WAIT_DONE before timeout; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  module enable; every state/counter update is qualified by it.
- op_valid  in  1  an opcode is presented.
- op_type  in  3  0 NOP, 1 RAPID (linear, pen up), 2 LINEAR (linear, pen down), 3 ARC_CW, 4 ARC_CCW, 5 PEN_UP, 6 PEN_DOWN, 7 illegal.
- op_ready  out  1  dispatcher can accept an opcode.
- linear_done_in  in  1  done from linear unit (level; high while that unit idles).
- circular_done_in  in  1  done from circular unit (level; high while that unit idles).
- trigger_linear  out  1  triggers linear unit.
- trigger_circular  out  1  triggers circular unit.
- circ_dir  out  1  arc direction for circular unit: 1 = CW, 0 = CCW.
- pen_down  out  1  servo command: 1 = down.
- done_out  out  1  high while idle with nothing pending.
- err_illegal  out  1  sticky; illegal opcode seen.
- err_timeout  out  1  sticky; watchdog expired.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; pen_down=0; circ_dir=0; counters=0; err_illegal=0; err_timeout=0.
  - Outputs during reset: op_ready=0, triggers=0, done_out=0.
  - Reset mid-operation aborts immediately. The pen goes up with no settle wait.
- States: IDLE, PEN_MOVE, TRIG, WAIT_DONE. Every transition happens on a posedge with clk_en=1; with clk_en=0 all registers hold.
- IDLE:
  - op_ready=1 and done_out=1.
  - Accept occurs on a posedge with clk_en & op_valid.
  - On accept, done_out drops combinationally in the same cycle, so the parent sees no race.
- Decode on accept:
  - NOP: stay in IDLE, consume the opcode.
  - 7 (illegal): set err_illegal, stay in IDLE, consume the opcode.
  - PEN_UP / PEN_DOWN: if the target differs from pen_down, update pen_down and go to PEN_MOVE. Otherwise stay in IDLE.
  - RAPID / LINEAR / ARC_*: target pen is up for RAPID and down for the others. Latch the unit select; for ARC_*, latch circ_dir.
    - If the target pen differs from pen_down: update pen_down and go to PEN_MOVE.
    - Otherwise go directly to TRIG.
- PEN_MOVE:
  - Counter increments on each enabled cycle.
  - Exit when the count equals PEN_SETTLE_CYCLES-1 (with PEN_SETTLE_CYCLES=0, exit after one enabled cycle).
  - Exit goes to TRIG if a motion is pending, else to IDLE.
  - pen_down changes exactly at the accept edge.
- TRIG:
  - The selected trigger is combinationally high for the whole state, while clk_en stays low included. Exactly one trigger is high.
  - Leave TRIG on the next enabled edge; this is exactly one enabled cycle.
  - done inputs are ignored in TRIG, because children report done while idle.
- WAIT_DONE:
  - Sample only the selected unit's done; the other unit's done is ignored.
  - On done=1, return to IDLE. done_out rises combinationally in that same cycle.
- Watchdog (when TIMEOUT_CYCLES>0):
  - Counts enabled cycles in WAIT_DONE.
  - Reaching TIMEOUT_CYCLES sets err_timeout, returns to IDLE and forces pen_down=0.
  - If done and timeout occur in the same cycle, done wins and no error is set.
- Error flags never block operation; only reset clears them.
- Counter widths: $clog2(param+1), minimum 1 bit. Counters clear on every state entry.
- circ_dir holds its last value until the next ARC opcode.

Test Plan:
- After reset, with clk_en=1 and PEN_SETTLE_CYCLES=4, send LINEAR (2):
  - pen_down rises at the accept edge.
  - PEN_MOVE lasts 4 cycles.
  - trigger_linear is high for exactly 1 cycle.
  - Hold linear_done_in=1 during TRIG: it is ignored.
  - Raise it 10 cycles later: IDLE and done_out=1 in that same cycle.
- Send ARC_CW (3) with the pen already down:
  - No PEN_MOVE.
  - trigger_circular is high one cycle after accept, with circ_dir=1.
  - Toggling linear_done_in during WAIT_DONE has no effect.
- With clk_en asserted every 3rd cycle, send RAPID after pen down:
  - PEN_MOVE takes 4 enabled cycles, i.e. 12 clk.
  - trigger_linear stays high for 3 clk.
  - The state holds across disabled cycles.
- Send opcodes 7, then 0, then 5 while pen up:
  - err_illegal=1 after the first.
  - op_ready stays high throughout; no trigger and no pen change.
- With TIMEOUT_CYCLES=20, trigger LINEAR and never assert done:
  - err_timeout=1 after 20 enabled cycles in WAIT_DONE.
  - Return to IDLE with pen_down=0.
  - A subsequent NOP is accepted.
- Assert reset=0 asynchronously mid-WAIT_DONE (not clock-aligned):
  - pen_down, triggers and op_ready drop immediately.
  - After release: IDLE, done_out=1, and err flags are 0.

Source files
------------

// File: rtl/op_dispatcher.sv
// Plotter command-path sequencer: applies the pen state each opcode needs, waits for
// the servo to settle, then triggers the linear or circular unit and waits for its done.
module op_dispatcher #(
  parameter int unsigned PEN_SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       op_valid,
  input  logic [2:0] op_type,
  output logic       op_ready,
  input  logic       linear_done_in,
  input  logic       circular_done_in,
  output logic       trigger_linear,
  output logic       trigger_circular,
  output logic       circ_dir,
  output logic       pen_down,
  output logic       done_out,
  output logic       err_illegal,
  output logic       err_timeout
);

  localparam int unsigned SW = (PEN_SETTLE_CYCLES > 0) ? $clog2(PEN_SETTLE_CYCLES + 1) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((PEN_SETTLE_CYCLES > 0) ? PEN_SETTLE_CYCLES - 1 : 0);
  localparam logic [TW-1:0] WD_LAST     = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_RAPID    = 3'd1;
  localparam logic [2:0] OP_LINEAR   = 3'd2;
  localparam logic [2:0] OP_ARC_CW   = 3'd3;
  localparam logic [2:0] OP_ARC_CCW  = 3'd4;
  localparam logic [2:0] OP_PEN_UP   = 3'd5;
  localparam logic [2:0] OP_PEN_DOWN = 3'd6;
  localparam logic [2:0] OP_ILLEGAL  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_PEN_MOVE, S_TRIG, S_WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic          pen_down_q, pen_down_d;
  logic          circ_dir_q, circ_dir_d;
  logic          sel_circ_q, sel_circ_d;
  logic          pend_q, pend_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          err_illegal_q, err_illegal_d;
  logic          err_timeout_q, err_timeout_d;

  logic sel_done, settle_last, wd_expire, pen_tgt;

  always_comb begin
    state_d       = state_q;
    pen_down_d    = pen_down_q;
    circ_dir_d    = circ_dir_q;
    sel_circ_d    = sel_circ_q;
    pend_d        = pend_q;
    settle_cnt_d  = settle_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    pen_tgt       = 1'b0;
    sel_done      = sel_circ_q ? circular_done_in : linear_done_in;
    settle_last   = (PEN_SETTLE_CYCLES <= 1) || (settle_cnt_q == SETTLE_LAST);
    wd_expire     = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);

    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            case (op_type)
              OP_NOP: ;
              OP_ILLEGAL: err_illegal_d = 1'b1;
              OP_PEN_UP, OP_PEN_DOWN: begin
                pen_tgt = (op_type == OP_PEN_DOWN);
                if (pen_tgt != pen_down_q) begin
                  pen_down_d   = pen_tgt;
                  pend_d       = 1'b0;
                  settle_cnt_d = '0;
                  state_d      = S_PEN_MOVE;
                end
              end
              default: begin
                pen_tgt    = (op_type != OP_RAPID);
                sel_circ_d = (op_type == OP_ARC_CW) || (op_type == OP_ARC_CCW);
                if (op_type == OP_ARC_CW || op_type == OP_ARC_CCW)
                  circ_dir_d = (op_type == OP_ARC_CW);
                pend_d = 1'b1;
                if (pen_tgt != pen_down_q) begin
                  pen_down_d   = pen_tgt;
                  settle_cnt_d = '0;
                  state_d      = S_PEN_MOVE;
                end else begin
                  state_d = S_TRIG;
                end
              end
            endcase
          end
        end
        S_PEN_MOVE: begin
          if (settle_last) begin
            settle_cnt_d = '0;
            state_d      = pend_q ? S_TRIG : S_IDLE;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        S_TRIG: begin
          wd_cnt_d = '0;
          state_d  = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // done has priority over a watchdog expiring on the same edge
          if (sel_done) begin
            pend_d   = 1'b0;
            wd_cnt_d = '0;
            state_d  = S_IDLE;
          end else if (wd_expire) begin
            err_timeout_d = 1'b1;
            pen_down_d    = 1'b0;
            pend_d        = 1'b0;
            wd_cnt_d      = '0;
            state_d       = S_IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pen_down_q    <= 1'b0;
      circ_dir_q    <= 1'b0;
      sel_circ_q    <= 1'b0;
      pend_q        <= 1'b0;
      settle_cnt_q  <= '0;
      wd_cnt_q      <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pen_down_q    <= pen_down_d;
      circ_dir_q    <= circ_dir_d;
      sel_circ_q    <= sel_circ_d;
      pend_q        <= pend_d;
      settle_cnt_q  <= settle_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Handshake outputs are gated by reset so they fall the moment reset asserts
  assign op_ready         = reset && (state_q == S_IDLE);
  assign trigger_linear   = reset && (state_q == S_TRIG) && !sel_circ_q;
  assign trigger_circular = reset && (state_q == S_TRIG) && sel_circ_q;
  assign done_out         = reset && (((state_q == S_IDLE) && !(clk_en && op_valid)) ||
                                      ((state_q == S_WAIT_DONE) && clk_en && sel_done));
  assign pen_down         = pen_down_q;
  assign circ_dir         = circ_dir_q;
  assign err_illegal      = err_illegal_q;
  assign err_timeout      = err_timeout_q;

endmodule

// File: tb/tb_op_dispatcher.sv
// Directed bench for op_dispatcher: per-cycle vector table plus hand-written
// timeout and asynchronous-reset sequences.
module tb_op_dispatcher;

  logic       clk, reset, clk_en, op_valid;
  logic [2:0] op_type;
  logic       linear_done_in, circular_done_in;
  logic       op_ready, trigger_linear, trigger_circular, circ_dir, pen_down;
  logic       done_out, err_illegal, err_timeout;

  int n_total = 0;
  int n_pass  = 0;

  op_dispatcher #(.PEN_SETTLE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .op_valid(op_valid), .op_type(op_type),
    .op_ready(op_ready), .linear_done_in(linear_done_in), .circular_done_in(circular_done_in),
    .trigger_linear(trigger_linear), .trigger_circular(trigger_circular), .circ_dir(circ_dir),
    .pen_down(pen_down), .done_out(done_out), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       v;
    logic [2:0] op;
    logic       ld;
    logic       cd;
    logic       rdy;
    logic       tl;
    logic       tc;
    logic       pen;
    logic       dn;
    logic       dir;
    logic       ill;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic v, input logic [2:0] op,
                              input logic ld, input logic cd, input logic rdy,
                              input logic tl, input logic tc, input logic pen,
                              input logic dn, input logic dir, input logic ill,
                              input logic to);
    vec_t r;
    r = '{en, v, op, ld, cd, rdy, tl, tc, pen, dn, dir, ill, to};
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_rep(input int n, input vec_t r);
    for (int i = 0; i < n; i++) vecs.push_back(r);
  endtask

  initial begin
    // T1: LINEAR from pen up, settle 4, trigger 1 cycle, done 10 cycles into WAIT_DONE
    vecs.push_back(mk(1,0,0,1,1, 1,0,0,0,1,0,0,0));
    vecs.push_back(mk(1,1,2,1,1, 1,0,0,0,0,0,0,0));
    add_rep(4, mk(1,0,0,1,1, 0,0,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,1, 0,1,0,1,0,0,0,0));
    add_rep(9, mk(1,0,0,0,1, 0,0,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,1, 0,0,0,1,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,1, 1,0,0,1,1,0,0,0));
    // T2: ARC_CW with pen already down, linear done toggling is ignored
    vecs.push_back(mk(1,1,3,1,1, 1,0,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,1, 0,0,1,1,0,1,0,0));
    vecs.push_back(mk(1,0,0,1,0, 0,0,0,1,0,1,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,1,0,1,0,0));
    vecs.push_back(mk(1,0,0,1,0, 0,0,0,1,0,1,0,0));
    vecs.push_back(mk(1,0,0,1,1, 0,0,0,1,1,1,0,0));
    vecs.push_back(mk(1,0,0,1,1, 1,0,0,1,1,1,0,0));
    // T3: clk_en every 3rd cycle, RAPID lifts the pen
    vecs.push_back(mk(0,1,1,1,1, 1,0,0,1,1,1,0,0));
    vecs.push_back(mk(1,1,1,1,1, 1,0,0,1,0,1,0,0));
    for (int i = 0; i < 4; i++) begin
      add_rep(2, mk(0,0,0,1,1, 0,0,0,0,0,1,0,0));
      vecs.push_back(mk(1,0,0,1,1, 0,0,0,0,0,1,0,0));
    end
    add_rep(2, mk(0,0,0,1,1, 0,1,0,0,0,1,0,0));
    vecs.push_back(mk(1,0,0,1,1, 0,1,0,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,0,0,0,0,1,0,0));
    vecs.push_back(mk(1,0,0,1,1, 0,0,0,0,1,1,0,0));
    vecs.push_back(mk(1,0,0,1,1, 1,0,0,0,1,1,0,0));
    // T4: illegal, NOP, PEN_UP with pen up: no movement
    vecs.push_back(mk(1,1,7,1,1, 1,0,0,0,0,1,0,0));
    vecs.push_back(mk(1,1,0,1,1, 1,0,0,0,0,1,1,0));
    vecs.push_back(mk(1,1,5,1,1, 1,0,0,0,0,1,1,0));
    vecs.push_back(mk(1,0,0,1,1, 1,0,0,0,1,1,1,0));
    // PEN_DOWN alone: settle then back to IDLE without a trigger
    vecs.push_back(mk(1,1,6,1,1, 1,0,0,0,0,1,1,0));
    add_rep(4, mk(1,0,0,1,1, 0,0,0,1,0,1,1,0));
    vecs.push_back(mk(1,0,0,1,1, 1,0,0,1,1,1,1,0));
    // ARC_CCW clears circ_dir; linear done low is ignored
    vecs.push_back(mk(1,1,4,1,1, 1,0,0,1,0,1,1,0));
    vecs.push_back(mk(1,0,0,1,1, 0,0,1,1,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,0,1,1,0,1,0));
    vecs.push_back(mk(1,0,0,1,1, 1,0,0,1,1,0,1,0));
    // PEN_UP to leave the pen up for the timeout test
    vecs.push_back(mk(1,1,5,1,1, 1,0,0,1,0,0,1,0));
    add_rep(4, mk(1,0,0,1,1, 0,0,0,0,0,0,1,0));
    vecs.push_back(mk(1,0,0,1,1, 1,0,0,0,1,0,1,0));

    reset = 1'b0; clk_en = 1'b0; op_valid = 1'b0; op_type = 3'd0;
    linear_done_in = 1'b1; circular_done_in = 1'b1;
    #12;
    chk("rst_op_ready", -1, op_ready, 1'b0);
    chk("rst_done_out", -1, done_out, 1'b0);
    chk("rst_pen_down", -1, pen_down, 1'b0);
    chk("rst_trig_lin", -1, trigger_linear, 1'b0);
    chk("rst_trig_circ", -1, trigger_circular, 1'b0);
    chk("rst_err_ill", -1, err_illegal, 1'b0);
    chk("rst_err_to", -1, err_timeout, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      clk_en = vecs[i].en; op_valid = vecs[i].v; op_type = vecs[i].op;
      linear_done_in = vecs[i].ld; circular_done_in = vecs[i].cd;
      #1;
      chk("op_ready", i, op_ready, vecs[i].rdy);
      chk("trigger_linear", i, trigger_linear, vecs[i].tl);
      chk("trigger_circular", i, trigger_circular, vecs[i].tc);
      chk("pen_down", i, pen_down, vecs[i].pen);
      chk("done_out", i, done_out, vecs[i].dn);
      chk("circ_dir", i, circ_dir, vecs[i].dir);
      chk("err_illegal", i, err_illegal, vecs[i].ill);
      chk("err_timeout", i, err_timeout, vecs[i].to);
      tick();
    end

    // Watchdog: LINEAR never completes, expires after 20 enabled WAIT_DONE cycles
    clk_en = 1'b1; op_valid = 1'b1; op_type = 3'd2; linear_done_in = 1'b0; circular_done_in = 1'b1;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("to_trig_lin", 0, trigger_linear, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 19) begin
        chk("to_err_before", i, err_timeout, 1'b0);
        chk("to_ready_before", i, op_ready, 1'b0);
        chk("to_pen_before", i, pen_down, 1'b1);
      end
      tick();
    end
    chk("to_err_after", 0, err_timeout, 1'b1);
    chk("to_ready_after", 0, op_ready, 1'b1);
    chk("to_pen_after", 0, pen_down, 1'b0);
    op_valid = 1'b1; op_type = 3'd0;
    #1;
    chk("to_nop_ready", 0, op_ready, 1'b1);
    chk("to_nop_done", 0, done_out, 1'b0);
    tick();
    op_valid = 1'b0;
    #1;
    chk("to_nop_idle_done", 0, done_out, 1'b1);
    chk("to_nop_idle_ready", 0, op_ready, 1'b1);

    // Asynchronous reset in the middle of WAIT_DONE
    op_valid = 1'b1; op_type = 3'd2; linear_done_in = 1'b0;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tick(); tick(); tick();
    chk("ar_pen_before", 0, pen_down, 1'b1);
    chk("ar_ready_before", 0, op_ready, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_pen", 0, pen_down, 1'b0);
    chk("ar_ready", 0, op_ready, 1'b0);
    chk("ar_trig_lin", 0, trigger_linear, 1'b0);
    chk("ar_trig_circ", 0, trigger_circular, 1'b0);
    chk("ar_done", 0, done_out, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("ar_rel_ready", 0, op_ready, 1'b1);
    chk("ar_rel_done", 0, done_out, 1'b1);
    chk("ar_rel_err_ill", 0, err_illegal, 1'b0);
    chk("ar_rel_err_to", 0, err_timeout, 1'b0);
    tick();
    chk("ar_idle_hold", 0, done_out, 1'b1);
    chk("ar_idle_pen", 0, pen_down, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
